// File: rtl/nn_pkg.sv
// nn_pkg: shared sizes, layer/state types and per-layer term count for the MNIST layer sequencer
package nn_pkg;
  localparam int N_IN = 784;
  localparam int N_HID = 20;
  localparam int N_OUT = 10;
  localparam int ADDR_W = 10;
  typedef logic [1:0] layer_t;
  typedef enum logic [2:0] {IDLE, CLEAR, RUN, FLUSH, STORE, DONE} seq_state_t;
  function automatic logic [ADDR_W-1:0] layer_terms(input layer_t l);
    return (l == 2'd0) ? ADDR_W'(N_IN) : ADDR_W'(N_HID);
  endfunction
endpackage

// File: rtl/valid_delay.sv
// valid_delay: DEPTH-stage issue-valid shift register with async clear and sync flush
module valid_delay #(
  parameter int DEPTH = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic flush,
  input  logic d,
  output logic q
);
  logic [DEPTH-1:0] sr_q, sr_d;
  always_comb sr_d = flush ? '0 : DEPTH'({sr_q, d});
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sr_q <= '0;
    else sr_q <= sr_d;
  assign q = sr_q[DEPTH-1];
endmodule

// File: rtl/nn_layer_sequencer.sv
// nn_layer_sequencer: steps the three FC layers through clear/run/flush/store over the shared neuron bank
module nn_layer_sequencer
  import nn_pkg::*;
#(
  parameter int MEM_LAT = 1,
  parameter int MAC_LAT = 2
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              Start,
  input  logic              Abort,
  output logic              Busy,
  output logic              Done,
  output layer_t            Layer,
  output logic [ADDR_W-1:0] Addr,
  output logic              Active,
  output logic              X_zero,
  output logic              Store
);
  localparam int FL_N = MEM_LAT + MAC_LAT + 1;
  localparam int FC_W = $clog2(FL_N + 1);
  seq_state_t state_q, state_d;
  layer_t layer_q, layer_d;
  logic [ADDR_W-1:0] k_q, k_d, k_last;
  logic [FC_W-1:0] fc_q, fc_d;
  logic dv;
  assign k_last = layer_terms(layer_q) - ADDR_W'(1);
  always_comb begin
    state_d = state_q;
    layer_d = layer_q;
    k_d = k_q;
    fc_d = '0;
    case (state_q)
      IDLE: if (Start) begin
        state_d = CLEAR;
        layer_d = '0;
      end
      CLEAR: begin
        state_d = RUN;
        k_d = '0;
      end
      RUN: if (k_q == k_last) state_d = FLUSH;
           else k_d = k_q + ADDR_W'(1);
      FLUSH: begin
        fc_d = fc_q + FC_W'(1);
        if (fc_q == FC_W'(FL_N - 1)) state_d = STORE;
      end
      STORE: begin
        k_d = '0;
        state_d = (layer_q == 2'd2) ? DONE : CLEAR;
        layer_d = (layer_q == 2'd2) ? layer_q : layer_q + 2'd1;
      end
      DONE: begin
        state_d = IDLE;
        layer_d = '0;
      end
      default: state_d = IDLE;
    endcase
    // abort overrides any transition, including an accepted start
    if (Abort) begin
      state_d = IDLE;
      layer_d = '0;
      k_d = '0;
      fc_d = '0;
    end
  end
  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) begin
      state_q <= IDLE;
      layer_q <= '0;
      k_q <= '0;
      fc_q <= '0;
    end else begin
      state_q <= state_d;
      layer_q <= layer_d;
      k_q <= k_d;
      fc_q <= fc_d;
    end
  valid_delay #(.DEPTH(MEM_LAT)) u_vd (
    .clk  (Clk),
    .rst_n(Reset_n),
    .flush(Abort),
    .d    (state_q == RUN),
    .q    (dv)
  );
  assign Busy = state_q != IDLE;
  assign Done = state_q == DONE;
  assign Store = state_q == STORE;
  assign Layer = layer_q;
  assign Addr = (state_q == RUN || state_q == FLUSH) ? k_q : '0;
  assign Active = dv | (state_q == FLUSH);
  assign X_zero = Active & ~dv;
endmodule

// File: tb/tb_nn_layer_sequencer.sv
// tb_nn_layer_sequencer: directed checks of layer timing, address trace, abort, async reset and back-to-back starts
module tb_nn_layer_sequencer;
  logic Clk = 1'b0, Reset_n, Start, Abort;
  logic Busy, Done, Active, X_zero, Store;
  logic [1:0] Layer;
  logic [9:0] Addr;
  int errors = 0, checks = 0;
  nn_layer_sequencer dut (
    .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .Abort(Abort),
    .Busy(Busy), .Done(Done), .Layer(Layer), .Addr(Addr),
    .Active(Active), .X_zero(X_zero), .Store(Store)
  );
  always #5 Clk = ~Clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge Clk);
    #1;
  endtask
  function automatic logic [31:0] outs();
    return {16'd0, Busy, Done, Store, Active, X_zero, Layer, Addr};
  endfunction
  task automatic full_run(input bit hold);
    int sc[3], sl[3];
    int ns = 0, done_c = -1, bad_busy = 0, bad_addr = 0, bad_act = 0, bad_xz = 0;
    longint acc = 0, p1 = 0, p2 = 0, zh = 0;
    Start = 1'b1;
    for (int c = 1; c <= 845; c++) begin
      step();
      if (!hold) Start = (c == 100);
      if (Store && ns < 3) begin
        sc[ns] = c;
        sl[ns] = int'(Layer);
        ns++;
      end
      if (Store && Layer == 2'd1) chk("z_layer1", 32'(zh >>> 11), 20 * 2048);
      if (Done) done_c = c;
      if (c <= 844 && Busy !== (c <= 843)) bad_busy++;
      if (c >= 2 && c <= 789 && Addr !== ((c <= 785) ? 10'(c - 2) : 10'd783)) bad_addr++;
      if (c <= 790 && Active !== (c >= 3 && c <= 789)) bad_act++;
      if (c <= 790 && X_zero !== (c >= 787 && c <= 789)) bad_xz++;
      if (Active) begin
        acc += p2;
        p2 = p1;
        p1 = X_zero ? 0 : 2048 * 2048;
        zh = acc;
      end else begin
        acc = 0;
        p1 = 0;
        p2 = 0;
      end
    end
    chk("busy_at_845", Busy, hold);
    chk("store_count", ns, 3);
    for (int i = 0; i < 3; i++) begin
      chk("store_cycle", (i < ns) ? sc[i] : -1, 790 + 26 * i);
      chk("store_layer", (i < ns) ? sl[i] : -1, i);
    end
    chk("done_cycle", done_c, 843);
    chk("busy_window", bad_busy, 0);
    chk("addr_trace_l0", bad_addr, 0);
    chk("active_l0", bad_act, 0);
    chk("xzero_l0", bad_xz, 0);
  endtask
  initial begin
    int seen;
    Reset_n = 1'b0;
    Start = 1'b0;
    Abort = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    chk("reset_outs", outs(), 0);
    Reset_n = 1'b1;
    step();
    chk("idle_outs", outs(), 0);
    full_run(1'b0);
    chk("idle_after_run", Busy, 0);
    Start = 1'b1;
    Abort = 1'b1;
    step();
    Start = 1'b0;
    Abort = 1'b0;
    chk("abort_on_start", Busy, 0);
    Start = 1'b1;
    for (int c = 1; c <= 400; c++) begin
      step();
      Start = 1'b0;
    end
    chk("busy_mid_l0", Busy, 1);
    Abort = 1'b1;
    step();
    Abort = 1'b0;
    chk("abort_active", Active, 0);
    chk("abort_busy", Busy, 0);
    chk("abort_addr", Addr, 0);
    seen = 0;
    for (int c = 0; c < 60; c++) begin
      step();
      if (Store || Done || Busy) seen++;
    end
    chk("abort_quiet", seen, 0);
    full_run(1'b0);
    Start = 1'b1;
    for (int c = 1; c <= 813; c++) begin
      step();
      Start = 1'b0;
    end
    chk("l1_flush_active", {Active, X_zero, Layer}, {1'b1, 1'b1, 2'd1});
    #2 Reset_n = 1'b0;
    #1 chk("async_reset_outs", outs(), 0);
    #2 Reset_n = 1'b1;
    step();
    chk("idle_after_reset", outs(), 0);
    full_run(1'b1);
    seen = -1;
    for (int c = 846; c <= 1700 && seen < 0; c++) begin
      step();
      Start = 1'b0;
      if (Store) seen = c;
    end
    chk("second_run_store", seen, 845 + 789);
    Abort = 1'b1;
    step();
    Abort = 1'b0;
    chk("final_idle", Busy, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/nn_layer_sequencer.md
# nn_layer_sequencer

Sequences the three fully-connected layers of the MNIST network (784→20, 20→20, 20→10) over the shared bank of `mult_accum`-based neurons. For each layer it clears the neuron accumulators, streams input/weight addresses, and holds `Active` until the multiply-accumulate pipeline has drained. It then pulses `Store` so the datapath captures the layer's `Z` outputs into the activation buffer, or into the result register for the final layer. It sits between the top-level start/done control and the neuron array, image ROM, weight ROMs and activation buffer.

## Interface
- `N_IN`, 784, input terms of layer 0
- `N_HID`, 20, neurons and terms of hidden layers
- `N_OUT`, 10, neurons in layer 2
- `MEM_LAT`, 1, read latency in cycles of image, activation and weight memories
- `MAC_LAT`, 2, `mult_accum` input-to-result latency in cycles
- `Clk`  in  1  system clock, all state on rising edge
- `Reset_n`  in  1  asynchronous, active-low reset
- `Start`  in  1  begin inference; sampled only in IDLE
- `Abort`  in  1  synchronous abort; return to IDLE next cycle
- `Busy`  out  1  high in every state except IDLE
- `Done`  out  1  one-cycle pulse after the last layer is stored
- `Layer`  out  2  current layer index, 0..2
- `Addr`  out  10  term index k, driven to both the X source and the W ROM of the current layer
- `Active`  out  1  to all neurons; low clears the accumulators and holds `Z`
- `X_zero`  out  1  datapath forces X=0 while this is high
- `Store`  out  1  one-cycle pulse; `Z` of layer `Layer` is valid and stable

## Operation
- Reset value of all outputs is 0; state is IDLE; k=0; valid pipe cleared.
- States are IDLE → CLEAR → RUN → FLUSH → STORE, then back to CLEAR for the next layer, or to DONE after layer 2, then IDLE.
- IDLE: when `Start` is high, go to CLEAR with `Layer`=0.
- CLEAR: lasts 1 cycle; `Active`=0; `Addr`=0; k←0.
- RUN: lasts K cycles, where K=784 for layer 0 and K=20 for layers 1 and 2.
  - `Addr`=k, incrementing each cycle.
  - An issue-valid bit enters a MEM_LAT-deep delay line.
  - On the cycle with k=K-1, go to FLUSH.
- FLUSH: lasts MEM_LAT+MAC_LAT+1 cycles; `Addr` holds at K-1.
- `Active` = delayed-valid OR (state==FLUSH).
  - `Active` is therefore 0 for the first MEM_LAT cycles of RUN, which keeps the accumulators clearing until the first data word arrives.
- `X_zero` = `Active` AND NOT delayed-valid, so only zero products enter the accumulator after the last real term.
- STORE: lasts 1 cycle; `Active`=0 (`Z` holds); `Store`=1.
  - Then `Layer`+1 and go to CLEAR; if `Layer`==2, go to DONE instead.
- DONE: lasts 1 cycle; `Done`=1; then go to IDLE.
- `Start` is ignored while `Busy` is high.
- `Abort` wins over every transition, including on the cycle `Start` is accepted.
  - Next state is IDLE, all outputs go to 0 and the delay line clears.
  - No `Store` or `Done` is issued for the aborted run.
- `Reset_n` low mid-run has the same effect as `Abort`, but takes effect immediately and asynchronously.
- `Addr` width is 10 bits; K-1 ≤ 783 fits, and there is no wrap-around.
- The counter compares against K-1 and never exceeds it.

## Timing
- One layer takes K+MEM_LAT+MAC_LAT+3 cycles.
- With default parameters that is 790 / 26 / 26 cycles.
- `Start` is sampled at edge 0:
  - CLEAR occupies cycle 1.
  - Layer-0 `Store` is in cycle 790.
  - Layer-1 `Store` is in cycle 816.
  - Layer-2 `Store` is in cycle 842.
  - `Done` is in cycle 843.
  - `Busy` is high for cycles 1..843.
- Address k issued in cycle c yields data at the neurons in cycle c+MEM_LAT; `Active` is high in that cycle.
- `Store` is asserted the cycle after the last FLUSH edge, so `Z` then holds the full sum >>11.
- Consecutive runs: `Start` is honoured in the first IDLE cycle after `Done`.

## Structure
- Shared package `nn_pkg` holds:
  - `N_IN`, `N_HID`, `N_OUT`
  - `ADDR_W`=10
  - `layer_t` (2-bit)
  - the `seq_state_t` enum {IDLE, CLEAR, RUN, FLUSH, STORE, DONE}
  - function `layer_terms(layer_t)` returning K
- One sub-module, `valid_delay`, is a parameterised MEM_LAT-stage shift register with async active-low clear and a synchronous flush input driven by `Abort`.
- Everything else is in the FSM and the k/flush counters of this module.

## Test plan
- Reset then `Start` pulse with defaults → `Store` in cycles 790, 816, 842 with `Layer`=0, 1, 2; `Done` in cycle 843; `Busy` low from cycle 844.
- Layer 0 address trace → `Addr` runs 0..783 contiguously.
  - `Active` rises in cycle 3 and stays high through cycle 789.
  - `X_zero` is high in cycles 787..789 only.
- Neuron model plus all-ones X and W (fixed-point 1.0 = 2048) on layer 1 → `Z`=20×2048 at the layer-1 `Store`, proving no lost or duplicated terms.
- `Abort` at cycle 400 → `Active`, `Busy` and `Addr` are 0 from cycle 401; no `Store` or `Done`; a new `Start` completes normally in 842+1 cycles.
- `Reset_n` low in the middle of layer 1 FLUSH → all outputs are 0 immediately (asynchronously); IDLE after release.
- `Start` held high through a whole run → a second run begins the cycle after `Done`; pulses asserted during `Busy` are ignored.
